// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two masters, the arbiter and the single-port memory.
// slave = arbiter side, master = the environment driving requests and the memory.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned BEW = DATA_WIDTH / 8;

    // Per-port request handshake: a request transfers in the cycle where
    // req_valid_i[p] & req_ready_o[p]; a response transfers when
    // resp_valid_o[p] & resp_ready_i[p]. Valid must not depend on ready.
    logic [1:0]                 req_valid_i;
    logic [1:0]                 req_ready_o;
    logic [1:0][63:0]           req_addr_i;
    logic [1:0]                 req_we_i;
    logic [1:0][BEW-1:0]        req_be_i;
    logic [1:0][DATA_WIDTH-1:0] req_wdata_i;
    logic [1:0]                 resp_valid_o;
    logic [1:0]                 resp_ready_i;
    logic [1:0][DATA_WIDTH-1:0] resp_rdata_o;
    logic [1:0]                 resp_err_o;
    logic                       mem_req_o;
    logic [63:0]                mem_addr_o;
    logic                       mem_we_o;
    logic [BEW-1:0]             mem_be_o;
    logic [DATA_WIDTH-1:0]      mem_wdata_o;
    logic                       mem_rvalid_i;
    logic [DATA_WIDTH-1:0]      mem_rdata_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
        input  resp_ready_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
        output resp_ready_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port core memory, with a
// response FIFO per port. Optional MISALIGN_ERR_EN rejects unaligned requests.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RESP_DEPTH = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
`ifdef MISALIGN_ERR_EN
    localparam int unsigned OFFW = $clog2(DATA_WIDTH / 8);
`endif

    logic rr_q, rr_d;
    logic infl_v_q, infl_v_d;
    logic infl_id_q, infl_id_d;
    logic infl_err_q, infl_err_d;

    logic [DATA_WIDTH-1:0] data_q [2][RESP_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [2][RESP_DEPTH];
    logic [RESP_DEPTH-1:0] err_q  [2];
    logic [RESP_DEPTH-1:0] err_d  [2];
    logic [PW-1:0]         wptr_q [2];
    logic [PW-1:0]         wptr_d [2];
    logic [PW-1:0]         rptr_q [2];
    logic [PW-1:0]         rptr_d [2];
    logic [CW-1:0]         cnt_q  [2];
    logic [CW-1:0]         cnt_d  [2];

    logic [1:0] resp_valid, pop, infl, elig, cand, grant, push;
    logic [CW:0] occ [2];
    logic        gid, any_grant, misalign;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A port is eligible only if its buffered + in-flight responses, after
    // this cycle's pop, leave room for one more; this makes overflow impossible.
    always_comb begin
        resp_valid = '0;
        pop        = '0;
        infl       = '0;
        elig       = '0;
        for (int p = 0; p < 2; p++) begin
            occ[p]        = '0;
            resp_valid[p] = (cnt_q[p] != '0);
            pop[p]        = resp_valid[p] & bus.resp_ready_i[p];
            infl[p]       = infl_v_q && (infl_id_q == 1'(p));
            occ[p]        = {1'b0, cnt_q[p]} - (CW+1)'(pop[p]) + (CW+1)'(infl[p]);
            elig[p]       = (occ[p] < (CW+1)'(RESP_DEPTH));
        end
        cand = bus.req_valid_i & elig;
        case (cand)
            2'b01:   gid = 1'b0;
            2'b10:   gid = 1'b1;
            default: gid = rr_q;
        endcase
        any_grant = |cand;
        grant     = any_grant ? (gid ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
`ifdef MISALIGN_ERR_EN
        misalign = |bus.req_addr_i[gid][OFFW-1:0];
`else
        misalign = 1'b0;
`endif
        bus.req_ready_o = grant;
        bus.mem_req_o   = any_grant & ~misalign;
        bus.mem_addr_o  = bus.req_addr_i[gid];
        bus.mem_we_o    = bus.req_we_i[gid];
        bus.mem_be_o    = bus.req_be_i[gid];
        bus.mem_wdata_o = bus.req_wdata_i[gid];
    end

    // FIFO head is read straight from the storage flops: no fall-through path.
    always_comb begin
        bus.resp_valid_o = resp_valid;
        bus.resp_rdata_o = '0;
        bus.resp_err_o   = '0;
        for (int p = 0; p < 2; p++) begin
            bus.resp_rdata_o[p] = data_q[p][rptr_q[p]];
            bus.resp_err_o[p]   = err_q[p][rptr_q[p]];
        end
    end

    always_comb begin
        rr_d       = rr_q;
        infl_v_d   = any_grant;
        infl_id_d  = infl_id_q;
        infl_err_d = any_grant & misalign;
        if (any_grant) begin
            rr_d      = ~gid;
            infl_id_d = gid;
        end

        data_d = data_q;
        err_d  = err_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        push   = '0;
        for (int p = 0; p < 2; p++) begin
            // A rejected request completes by itself; a forwarded one waits for rvalid.
            push[p] = infl_v_q && (infl_id_q == 1'(p)) && (infl_err_q || bus.mem_rvalid_i);
            if (push[p]) begin
                data_d[p][wptr_q[p]] = infl_err_q ? '0 : bus.mem_rdata_i;
                err_d[p][wptr_q[p]]  = infl_err_q;
                wptr_d[p]            = ptr_inc(wptr_q[p]);
            end
            if (pop[p]) begin
                rptr_d[p] = ptr_inc(rptr_q[p]);
            end
            cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= 1'b0;
            infl_v_q   <= 1'b0;
            infl_id_q  <= 1'b0;
            infl_err_q <= 1'b0;
            data_q     <= '{default: '0};
            err_q      <= '{default: '0};
            wptr_q     <= '{default: '0};
            rptr_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
        end else begin
            rr_q       <= rr_d;
            infl_v_q   <= infl_v_d;
            infl_id_q  <= infl_id_d;
            infl_err_q <= infl_err_d;
            data_q     <= data_d;
            err_q      <= err_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
